// File: rtl/arm_ex_pkg.sv
// Shared definitions for the ARM execute stage: condition codes, data-processing
// opcodes, NZCV bit positions and the condition evaluator.
package arm_ex_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } dp_op_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic condpass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: condpass = z;
      COND_NE: condpass = ~z;
      COND_CS: condpass = c;
      COND_CC: condpass = ~c;
      COND_MI: condpass = n;
      COND_PL: condpass = ~n;
      COND_VS: condpass = v;
      COND_VC: condpass = ~v;
      COND_HI: condpass = c & ~z;
      COND_LS: condpass = ~c | z;
      COND_GE: condpass = (n == v);
      COND_LT: condpass = (n != v);
      COND_GT: condpass = ~z & (n == v);
      COND_LE: condpass = z | (n != v);
      COND_AL: condpass = 1'b1;
      default: condpass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ARM data-processing ALU producing the result and the NZCV
// value that instruction would write.
module alu_core
  import arm_ex_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  opcode,
  input  logic        carry_in,
  input  logic        overflow_in,
  output logic [31:0] result,
  output logic [3:0]  nzcv_next
);

  logic [31:0] x, y;
  logic        cin;
  logic        arith;
  logic [32:0] sum;

  // Every arithmetic op is x + y + cin; subtracts invert one operand so the
  // adder carry-out is directly ARM's NOT-borrow.
  always_comb begin
    x      = a;
    y      = b;
    cin    = 1'b0;
    arith  = 1'b1;
    result = '0;
    case (opcode)
      OP_AND, OP_TST: begin result = a & b;  arith = 1'b0; end
      OP_EOR, OP_TEQ: begin result = a ^ b;  arith = 1'b0; end
      OP_ORR:         begin result = a | b;  arith = 1'b0; end
      OP_MOV:         begin result = b;      arith = 1'b0; end
      OP_BIC:         begin result = a & ~b; arith = 1'b0; end
      OP_MVN:         begin result = ~b;     arith = 1'b0; end
      OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
      OP_ADC:         cin = carry_in;
      OP_SBC:         begin y = ~b; cin = carry_in; end
      OP_RSC:         begin x = b; y = ~a; cin = carry_in; end
      default:        cin = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'b0, cin};
    if (arith) result = sum[31:0];
    nzcv_next[FLAG_N] = result[31];
    nzcv_next[FLAG_Z] = (result == '0);
    nzcv_next[FLAG_C] = arith ? sum[32] : carry_in;
    nzcv_next[FLAG_V] = arith ? ((x[31] == y[31]) && (result[31] != x[31])) : overflow_in;
  end

endmodule

// File: rtl/execute_stage.sv
// ARM EX stage: condition check, ALU, load/store address generation and branch
// resolution, all registered into the EX/MEM boundary; owns CPSR NZCV.
module execute_stage
  import arm_ex_pkg::*;
#(
  parameter int unsigned BRANCH_SHADOW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] imm32,
  input  logic        use_imm,
  input  logic [31:0] store_val,
  input  logic [4:0]  opcode,
  input  logic [3:0]  cond,
  input  logic        set_flags,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic        is_branch,
  input  logic        link,
  input  logic [23:0] branch_off,
  input  logic [31:0] pc_plus8,
  input  logic        is_mem,
  input  logic        load_store,
  input  logic        pre_post,
  input  logic        up_down,
  input  logic        byte_word,
  input  logic        write_back,
  output logic        out_valid,
  output logic [31:0] alu_result,
  output logic [3:0]  rd_out,
  output logic        reg_write,
  output logic [31:0] mem_addr,
  output logic [31:0] store_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_byte,
  output logic        base_wb_en,
  output logic [31:0] base_wb_val,
  output logic [3:0]  base_reg,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [3:0]  flags
);

  localparam logic [1:0] SHADOW_INIT = BRANCH_SHADOW[1:0];

  logic [1:0]  shadow;
  logic        squashing;
  logic        exec;
  logic        is_compare;
  logic [31:0] op2;
  logic [31:0] calc;
  logic [31:0] br_target;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;

  assign squashing  = (shadow != 2'd0);
  assign exec       = in_valid & ~stall & ~squashing & condpass(cond, flags);
  assign is_compare = (opcode[3:2] == 2'b10);
  assign op2        = use_imm ? imm32 : data2;
  assign calc       = up_down ? (data1 + op2) : (data1 - op2);
  assign br_target  = pc_plus8 + {{6{branch_off[23]}}, branch_off, 2'b00};

  alu_core u_alu (
    .a           (data1),
    .b           (op2),
    .opcode      (opcode[3:0]),
    .carry_in    (flags[FLAG_C]),
    .overflow_in (flags[FLAG_V]),
    .result      (alu_out),
    .nzcv_next   (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      rd_out        <= '0;
      reg_write     <= 1'b0;
      mem_addr      <= '0;
      store_data    <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_byte      <= 1'b0;
      base_wb_en    <= 1'b0;
      base_wb_val   <= '0;
      base_reg      <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      flags         <= '0;
      shadow        <= '0;
    end else if (!stall) begin
      out_valid     <= exec;
      alu_result    <= alu_out;
      rd_out        <= rd;
      reg_write     <= 1'b0;
      mem_addr      <= pre_post ? calc : data1;
      store_data    <= store_val;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_byte      <= 1'b0;
      base_wb_en    <= 1'b0;
      base_wb_val   <= calc;
      base_reg      <= rn;
      branch_taken  <= 1'b0;
      branch_target <= br_target;
      if (in_valid && squashing) shadow <= shadow - 2'd1;
      if (exec) begin
        if (is_branch) begin
          branch_taken <= 1'b1;
          shadow       <= SHADOW_INIT;
          if (link) begin
            reg_write  <= 1'b1;
            rd_out     <= 4'd14;
            alu_result <= pc_plus8 - 32'd4;
          end
        end else if (is_mem) begin
          mem_read   <= load_store;
          mem_write  <= ~load_store;
          mem_byte   <= byte_word;
          base_wb_en <= write_back | ~pre_post;
          reg_write  <= load_store;
        end else if (!opcode[4]) begin
          reg_write <= ~is_compare;
          if (set_flags || is_compare) flags <= alu_flags;
        end
      end
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage of the 5-stage ARM pipeline. Consumes the registered outputs of the register-fetch/execute pipeline register.
- Evaluates the condition field against the internal CPSR NZCV register and runs the data-processing ALU. Also computes load/store addresses with base writeback, and branch targets with link.
- Registers all results into the EX/MEM boundary, so the stage ends in its own pipeline register.
- Owns the NZCV flags and squashes wrong-path instructions after a taken branch.

Parameters:
- BRANCH_SHADOW, 2: number of valid instructions squashed after a taken branch (range 0..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold: inputs ignored; CPSR, shadow counter and outputs frozen
- in_valid  in  1  upstream holds a real instruction
- data1  in  32  Rn / base
- data2  in  32  Rm / register offset
- imm32  in  32  decoded immediate (already rotated)
- use_imm  in  1  operand2/offset = imm32, else data2
- store_val  in  32  Rd value for stores
- opcode  in  5  [3:0] ARM DP opcode; [4]=1 reserved
- cond  in  4  ARM condition field
- set_flags  in  1  S bit
- rd  in  4  destination register
- is_branch, link  in  1,1  B / BL
- branch_off  in  24  signed word offset
- pc_plus8  in  32  PC of instruction + 8
- is_mem, load_store, pre_post, up_down, byte_word, write_back  in  1 each  SDT controls (load=1, pre=1, up=1, byte=1)
- out_valid  out  1  EX/MEM entry valid
- alu_result  out  32  DP result, or link value
- rd_out  out  4  destination (14 for link)
- reg_write  out  1  write rd_out with alu_result
- mem_addr  out  32  memory address
- store_data  out  32
- mem_read, mem_write, mem_byte  out  1 each
- base_wb_en  out  1  write base_wb_val to base register
- base_wb_val  out  32
- base_reg  out  4  base register number (input rn added: rn in 4)
- branch_taken  out  1  one-cycle pulse
- branch_target  out  32
- flags  out  4  current CPSR NZCV {N,Z,C,V}

Behaviour:
- Reset: all outputs 0, NZCV=0000, shadow counter 0. Reset mid-operation discards any in-flight entry and any pending squash.
- Latency: 1 cycle, registered. The instruction on the inputs at edge k produces outputs valid after edge k.
- Flag forwarding: NZCV updates on the same edge as the outputs, so the next instruction sees the new flags with no bubble.
- Execute condition: exec = in_valid & ~stall & ~squashing & condpass(cond, NZCV).
- Condition codes: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE follow standard ARM; AL=1110 always passes; 1111 never passes.
- Not executed: out_valid=0 and every write/enable output 0. alu_result and the address outputs may hold don't-care values.
- ALU: op2 = use_imm ? imm32 : data2. ADD/ADC/SUB/SBC/RSB/RSC use 33-bit carry.
  - Subtract carry = NOT borrow.
  - V = signed overflow.
- Logical ops (AND EOR ORR BIC MOV MVN TST TEQ): when flags are set, they update N and Z only; C and V are kept.
- Compare ops: TST TEQ CMP CMN always update flags regardless of set_flags, and reg_write=0.
- Flag update: NZCV updates only when exec & DP & (set_flags | compare).
- Reserved opcode: opcode[4]=1 with neither is_mem nor is_branch gives out_valid=1 with no writes (NOP).
- Memory path: off = use_imm ? imm32 : data2.
  - calc = up_down ? data1+off : data1-off, mod 2^32.
  - mem_addr = pre_post ? calc : data1.
  - base_wb_en = write_back | ~pre_post; base_wb_val = calc.
  - mem_read = load_store; mem_write = ~load_store; mem_byte = byte_word.
  - Load: reg_write=1, rd_out=rd; alu_result is unused.
  - NZCV is never touched by the memory path.
- Branch path: branch_target = pc_plus8 + {{6{branch_off[23]}}, branch_off, 2'b00}, mod 2^32; branch_taken=1.
  - With link: reg_write=1, rd_out=14, alu_result = pc_plus8 - 4.
- Squash: on a taken branch, the counter loads BRANCH_SHADOW. While it is nonzero, each cycle with in_valid & ~stall decrements it and the instruction is squashed.
  - A squashed branch cannot retrigger the counter.
  - Cycles with in_valid=0 do not decrement.
  - BRANCH_SHADOW=0 disables squashing.
- Stall: outputs, NZCV and counter hold their values. branch_taken holds too; the consumer qualifies it with stall.

Decomposition:
- Package arm_ex_pkg: condition-code constants, DP opcode constants, NZCV bit indices, and a condpass function.
- Sub-module alu_core (combinational): inputs a, b, opcode, carry_in; outputs result[31:0] and nzcv_next[3:0], with the logical/compare flag rules above.

Test Plan:
- ADDS data1=7FFFFFFF, op2=1, AL, S=1 -> alu_result=80000000, flags=1001, reg_write=1.
- CMP 5,5 then ADDNE -> flags Z=1 (C=1); next cycle out_valid=0, flags unchanged.
- BL branch_off=FFFFFE, pc_plus8=1008 -> branch_target=1000, rd_out=14, alu_result=1004. The next two valid instructions are squashed; the third executes.
- LDR post-index, up, data1=100, imm=4 -> mem_addr=100, base_wb_en=1, base_wb_val=104, mem_read=1.
- STRB pre-index, down, no writeback, data1=200, data2=10 -> mem_addr=1F0, base_wb_en=0, mem_byte=1, store_data=store_val.
- Stall held for 3 cycles mid-ADDS with reset asserted on the 4th cycle -> outputs and flags frozen during the stall, then all zero after reset; pending squash cleared.
